// File: rtl/udma_ch_evt_decoder.sv
//------------------------------------------------------------------------------
// Module   : udma_ch_evt_decoder
// Purpose  : Serializes uDMA linear-channel end-of-transfer pulses into
//            per-peripheral events (round-robin, one per accepted slot).
//            Optional sticky overflow detection: define UDMA_EVT_OVF_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module udma_ch_evt_decoder #(
  parameter int N_TX     = 8,
  parameter int N_RX     = 6,
  parameter int PER_ID_W = 4
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [N_TX-1:0]      tx_lin_evt_i,
  input  logic [N_RX-1:0]      rx_lin_evt_i,
  output logic                 evt_valid_o,
  input  logic                 evt_ready_i,
  output logic [PER_ID_W-1:0]  evt_per_id_o,
  output logic                 evt_dir_o,
  output logic                 evt_cmd_o,
  output logic [N_RX+N_TX-1:0] ovf_o,
  input  logic                 ovf_clr_i
);

  localparam int c_n_src = N_RX + N_TX;
  localparam int c_src_w = (c_n_src > 1) ? $clog2(c_n_src) : 1;

  // Channel and peripheral allocation of udma_cfg_pkg, decoded in reverse.
  localparam int c_n_qspim          = 1;
  localparam int c_n_i2c            = 2;
  localparam int c_per_id_uart      = 0;
  localparam int c_per_id_qspim     = 1;
  localparam int c_per_id_i2c       = 2;
  localparam int c_per_id_cpi       = 4;
  localparam int c_per_id_hyper     = 6;
  localparam int c_ch_tx_uart       = 0;
  localparam int c_ch_tx_qspim      = 1;
  localparam int c_ch_tx_cmd_qspim  = 2;
  localparam int c_ch_tx_i2c        = 3;
  localparam int c_ch_tx_cmd_i2c    = 5;
  localparam int c_ch_tx_hyper      = 7;
  localparam int c_ch_rx_uart       = 0;
  localparam int c_ch_rx_qspim      = 1;
  localparam int c_ch_rx_i2c        = 2;
  localparam int c_ch_rx_cpi        = 4;
  localparam int c_ch_rx_hyper      = 5;

  // Returns {per_id, dir, cmd} for source index s.
  function automatic logic [PER_ID_W+1:0] f_decode(input int s);
    int   pid;
    int   ch;
    logic dir;
    logic cmd;
    pid = 0;
    cmd = 1'b0;
    if (s < N_RX) begin
      ch  = s;
      dir = 1'b0;
      if (ch == c_ch_rx_uart)  pid = c_per_id_uart;
      if (ch == c_ch_rx_cpi)   pid = c_per_id_cpi;
      if (ch == c_ch_rx_hyper) pid = c_per_id_hyper;
      for (int i = 0; i < c_n_qspim; i++)
        if (ch == c_ch_rx_qspim + i) pid = c_per_id_qspim + i;
      for (int i = 0; i < c_n_i2c; i++)
        if (ch == c_ch_rx_i2c + i) pid = c_per_id_i2c + i;
    end else begin
      ch  = s - N_RX;
      dir = 1'b1;
      if (ch == c_ch_tx_uart)  pid = c_per_id_uart;
      if (ch == c_ch_tx_hyper) pid = c_per_id_hyper;
      for (int i = 0; i < c_n_qspim; i++) begin
        if (ch == c_ch_tx_qspim + i) pid = c_per_id_qspim + i;
        if (ch == c_ch_tx_cmd_qspim + i) begin
          pid = c_per_id_qspim + i;
          cmd = 1'b1;
        end
      end
      for (int i = 0; i < c_n_i2c; i++) begin
        if (ch == c_ch_tx_i2c + i) pid = c_per_id_i2c + i;
        if (ch == c_ch_tx_cmd_i2c + i) begin
          pid = c_per_id_i2c + i;
          cmd = 1'b1;
        end
      end
    end
    return {PER_ID_W'(pid), dir, cmd};
  endfunction

  logic [c_n_src-1:0]  w_pulse;
  logic [c_n_src-1:0]  r_pend;
  logic [c_src_w-1:0]  r_ptr;
  logic [c_src_w-1:0]  w_win;
  logic                w_found;
  int                  w_idx;
  logic                w_grant;
  logic [c_n_src-1:0]  w_grant_vec;
  logic [PER_ID_W+1:0] w_dec;
  logic                r_valid;
  logic [PER_ID_W-1:0] r_per_id;
  logic                r_dir;
  logic                r_cmd;

  assign w_pulse = {tx_lin_evt_i, rx_lin_evt_i};

  // First pending source at or above r_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = 0; k < c_n_src; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= c_n_src) w_idx = w_idx - c_n_src;
      if (!w_found && r_pend[w_idx]) begin
        w_found = 1'b1;
        w_win   = c_src_w'(w_idx);
      end
    end
  end

  assign w_grant     = w_found && (!r_valid || evt_ready_i);
  assign w_grant_vec = w_grant ? ({{(c_n_src-1){1'b0}}, 1'b1} << w_win) : '0;
  assign w_dec       = f_decode(int'(w_win));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_pend   <= '0;
      r_ptr    <= '0;
      r_valid  <= 1'b0;
      r_per_id <= '0;
      r_dir    <= 1'b0;
      r_cmd    <= 1'b0;
    end else begin
      // A pulse landing on the grant cycle keeps the source pending.
      r_pend <= (r_pend & ~w_grant_vec) | w_pulse;
      if (w_grant) begin
        r_ptr    <= (w_win == c_src_w'(c_n_src - 1)) ? '0 : w_win + 1'b1;
        r_valid  <= 1'b1;
        r_per_id <= w_dec[PER_ID_W+1:2];
        r_dir    <= w_dec[1];
        r_cmd    <= w_dec[0];
      end else if (evt_ready_i) begin
        r_valid  <= 1'b0;
      end
    end
  end

  assign evt_valid_o  = r_valid;
  assign evt_per_id_o = r_per_id;
  assign evt_dir_o    = r_dir;
  assign evt_cmd_o    = r_cmd;

`ifdef UDMA_EVT_OVF_EN
  logic [c_n_src-1:0] r_ovf;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ovf <= '0;
    end else begin
      // A new overflow wins over a simultaneous clear.
      r_ovf <= (ovf_clr_i ? '0 : r_ovf) | (w_pulse & r_pend & ~w_grant_vec);
    end
  end

  assign ovf_o = r_ovf;
`else
  logic w_unused_ovf_clr;
  assign w_unused_ovf_clr = ovf_clr_i;
  assign ovf_o            = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_udma_ch_evt_decoder.sv
//------------------------------------------------------------------------------
// Module   : tb_udma_ch_evt_decoder
// Purpose  : Directed self-checking bench for udma_ch_evt_decoder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_udma_ch_evt_decoder;

  localparam int N_TX     = 8;
  localparam int N_RX     = 6;
  localparam int PER_ID_W = 4;
  localparam int N_SRC    = N_RX + N_TX;

  logic                clk;
  logic                rstn;
  logic [N_TX-1:0]     tx_evt;
  logic [N_RX-1:0]     rx_evt;
  logic                evt_valid;
  logic                evt_ready;
  logic [PER_ID_W-1:0] evt_per_id;
  logic                evt_dir;
  logic                evt_cmd;
  logic [N_SRC-1:0]    ovf;
  logic                ovf_clr;

  int n_cmp;
  int n_err;
  int exp_pid [N_SRC];
  int exp_cmd [N_SRC];
  logic [N_SRC-1:0] exp_ovf;

  udma_ch_evt_decoder #(
    .N_TX     (N_TX),
    .N_RX     (N_RX),
    .PER_ID_W (PER_ID_W)
  ) u_dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .tx_lin_evt_i (tx_evt),
    .rx_lin_evt_i (rx_evt),
    .evt_valid_o  (evt_valid),
    .evt_ready_i  (evt_ready),
    .evt_per_id_o (evt_per_id),
    .evt_dir_o    (evt_dir),
    .evt_cmd_o    (evt_cmd),
    .ovf_o        (ovf),
    .ovf_clr_i    (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [N_SRC-1:0] srcs);
    rx_evt = srcs[N_RX-1:0];
    tx_evt = srcs[N_SRC-1:N_RX];
    tick();
    rx_evt = '0;
    tx_evt = '0;
  endtask

  task automatic chk_beat(input string tag, input int s);
    chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
    chk({tag, "_pid"},   32'(evt_per_id), 32'(exp_pid[s]));
    chk({tag, "_dir"},   32'(evt_dir), (s >= N_RX) ? 32'd1 : 32'd0);
    chk({tag, "_cmd"},   32'(evt_cmd), 32'(exp_cmd[s]));
  endtask

  initial begin
    int src_order [3];
    logic [PER_ID_W-1:0] held_pid;
    logic held_dir;
    n_cmp = 0;
    n_err = 0;
    exp_pid = '{0, 1, 2, 3, 4, 6, 0, 1, 1, 2, 3, 2, 3, 6};
    exp_cmd = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0};
    rstn = 1'b0; tx_evt = '0; rx_evt = '0; evt_ready = 1'b1; ovf_clr = 1'b0;

    // Reset state
    #12;
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_pid",   32'(evt_per_id), 32'd0);
    chk("rst_ovf",   32'(ovf), 32'd0);
    tick();
    rstn = 1'b1;
    tick();

    // Single event: TX2 = QSPIM command channel, two-cycle latency
    pulse(14'(1) << (N_RX + 2));
    chk("single_lat", 32'(evt_valid), 32'd0);
    tick();
    chk_beat("single", N_RX + 2);
    tick();
    chk("single_once", 32'(evt_valid), 32'd0);

    // Full mapping, one source at a time
    for (int s = 0; s < N_SRC; s++) begin
      pulse(14'(1) << s);
      tick();
      chk_beat($sformatf("map%0d", s), s);
      tick();
    end

    // All sources at once: 14 back-to-back beats in source order
    pulse('1);
    for (int s = 0; s < N_SRC; s++) begin
      tick();
      chk_beat($sformatf("all%0d", s), s);
    end
    tick();
    chk("all_done", 32'(evt_valid), 32'd0);

    // Pointer wrapped to 0: source 0 beats source 13
    pulse(14'(1) | (14'(1) << 13));
    tick();
    chk_beat("wrap_a", 0);
    tick();
    chk_beat("wrap_b", 13);
    tick();
    chk("wrap_done", 32'(evt_valid), 32'd0);

    // Backpressure with three pending events
    evt_ready = 1'b0;
    src_order = '{1, 9, 11};
    pulse((14'(1) << 1) | (14'(1) << 9) | (14'(1) << 11));
    tick();
    chk_beat("bp_first", 1);
    held_pid = evt_per_id;
    held_dir = evt_dir;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("bp_hold_v%0d", i), 32'(evt_valid), 32'd1);
      chk($sformatf("bp_hold_p%0d", i), 32'(evt_per_id), 32'(held_pid));
      chk($sformatf("bp_hold_d%0d", i), 32'(evt_dir), 32'(held_dir));
    end
    evt_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_beat($sformatf("bp_beat%0d", i), src_order[i]);
      tick();
    end
    chk("bp_done", 32'(evt_valid), 32'd0);

    // Overflow: slot busy with RX0, then two pulses on RX4 (CPI)
    evt_ready = 1'b0;
    pulse(14'(1));
    tick();
    chk_beat("ovf_slot", 0);
    pulse(14'(1) << 4);
    chk("ovf_none", 32'(ovf), 32'd0);
    pulse(14'(1) << 4);
`ifdef UDMA_EVT_OVF_EN
    exp_ovf = 14'(1) << 4;
`else
    exp_ovf = '0;
`endif
    chk("ovf_set", 32'(ovf), 32'(exp_ovf));
    evt_ready = 1'b1;
    chk_beat("ovf_beat0", 0);
    tick();
    chk_beat("ovf_beat1", 4);
    tick();
    chk("ovf_done", 32'(evt_valid), 32'd0);
    chk("ovf_sticky", 32'(ovf), 32'(exp_ovf));
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'd0);

    // Reset while an event is held and another is pending
    evt_ready = 1'b0;
    pulse((14'(1) << 2) | (14'(1) << 13));
    tick();
    chk("rmid_valid_pre", 32'(evt_valid), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("rmid_valid", 32'(evt_valid), 32'd0);
    chk("rmid_pid",   32'(evt_per_id), 32'd0);
    chk("rmid_dir",   32'(evt_dir), 32'd0);
    chk("rmid_cmd",   32'(evt_cmd), 32'd0);
    tick();
    rstn = 1'b1;
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rmid_stale%0d", i), 32'(evt_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
